// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - valid/ready/data handshake bundle for pipe_stage_buf
interface pipe_stage_buf_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - pipeline stage register with handshake, optional skid entry, hold/deferred flush, stall counter
module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 64,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    pipe_stage_buf_if.slave   in_if,
    pipe_stage_buf_if.master  out_if,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic              flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [1:0]        occ_q, occ_d;

    logic kill;
    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;
    logic [CNT_W-1:0] stall_inc;

    assign kill      = flush | flush_pend_q;
    assign out_valid = ~hold & ~kill & m_valid_q;
    assign in_fire   = in_if.valid & in_ready;
    assign out_fire  = out_valid & out_if.ready;
    assign stall_inc = (stall_cnt_q == {CNT_W{1'b1}}) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);

    // With the skid entry, in_ready depends only on a flop so out_ready never reaches upstream.
    always_comb begin
        in_ready = 1'b0;
        if (!hold && !kill) begin
            if (SKID != 0) in_ready = ~s_valid_q;
            else           in_ready = ~m_valid_q | out_if.ready;
        end
    end

    always_comb begin
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        s_valid_d    = s_valid_q;
        s_data_d     = s_data_q;
        flush_pend_d = flush_pend_q;
        stall_cnt_d  = stall_cnt_q;
        if (hold) begin
            flush_pend_d = flush_pend_q | flush;
            stall_cnt_d  = stall_inc;
        end else if (kill) begin
            m_valid_d    = 1'b0;
            m_data_d     = '0;
            s_valid_d    = 1'b0;
            s_data_d     = '0;
            flush_pend_d = 1'b0;
            stall_cnt_d  = '0;
        end else begin
            stall_cnt_d = (m_valid_q && !out_if.ready) ? stall_inc : '0;
            if (SKID != 0) begin
                if (out_fire) begin
                    if (s_valid_q) begin
                        m_data_d  = s_data_q;
                        s_valid_d = 1'b0;
                    end else begin
                        m_valid_d = in_fire;
                        if (in_fire) m_data_d = in_if.data;
                    end
                end else if (in_fire) begin
                    if (!m_valid_q) begin
                        m_valid_d = 1'b1;
                        m_data_d  = in_if.data;
                    end else begin
                        s_valid_d = 1'b1;
                        s_data_d  = in_if.data;
                    end
                end
            end else begin
                if (in_fire) begin
                    m_valid_d = 1'b1;
                    m_data_d  = in_if.data;
                end else if (out_fire) begin
                    m_valid_d = 1'b0;
                end
            end
        end
        occ_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            s_valid_q    <= 1'b0;
            s_data_q     <= '0;
            flush_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
            occ_q        <= 2'd0;
        end else begin
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            s_valid_q    <= s_valid_d;
            s_data_q     <= s_data_d;
            flush_pend_q <= flush_pend_d;
            stall_cnt_q  <= stall_cnt_d;
            occ_q        <= occ_d;
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = m_data_q;
    assign occ          = occ_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_hold, a_flush, b_hold, b_flush;
    logic [1:0]  a_occ, b_occ;
    logic [63:0] a_cnt;
    logic [3:0]  b_cnt;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DATA_W(64)) a_in ();
    pipe_stage_buf_if #(.DATA_W(64)) a_out ();
    pipe_stage_buf_if #(.DATA_W(8))  b_in ();
    pipe_stage_buf_if #(.DATA_W(8))  b_out ();

    pipe_stage_buf #(.DATA_W(64), .CNT_W(64), .SKID(1)) dut_a (
        .clk(clk), .reset(reset), .hold(a_hold), .flush(a_flush),
        .in_if(a_in), .out_if(a_out), .occ(a_occ), .stall_cnt(a_cnt)
    );

    pipe_stage_buf #(.DATA_W(8), .CNT_W(4), .SKID(0)) dut_b (
        .clk(clk), .reset(reset), .hold(b_hold), .flush(b_flush),
        .in_if(b_in), .out_if(b_out), .occ(b_occ), .stall_cnt(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        a_hold = 1'b0; a_flush = 1'b0; b_hold = 1'b0; b_flush = 1'b0;
        a_in.valid = 1'b1; a_in.data = 64'h77; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.data = 8'h00; b_out.ready = 1'b0;

        // reset held two cycles with in_valid asserted
        tick(); tick();
        check_eq("rst_out_valid", a_out.valid, 1'b0);
        check_eq("rst_occ", a_occ, 2'd0);
        check_eq("rst_cnt", a_cnt, 64'd0);
        check_eq("rst_b_occ", b_occ, 2'd0);
        reset = 1'b1;
        #1;
        check_eq("rel_in_ready", a_in.ready, 1'b1);
        check_eq("rel_out_valid", a_out.valid, 1'b0);
        tick();
        check_eq("first_fire_valid", a_out.valid, 1'b1);
        check_eq("first_fire_data", a_out.data, 64'h77);

        // back-to-back stream 1,2,3
        a_out.ready = 1'b1; a_in.data = 64'd1;
        tick();
        a_in.data = 64'd2;
        check_eq("stream1_valid", a_out.valid, 1'b1);
        check_eq("stream1_data", a_out.data, 64'd1);
        tick();
        a_in.data = 64'd3;
        check_eq("stream2_data", a_out.data, 64'd2);
        check_eq("stream2_in_ready", a_in.ready, 1'b1);
        tick();
        a_in.valid = 1'b0;
        check_eq("stream3_valid", a_out.valid, 1'b1);
        check_eq("stream3_data", a_out.data, 64'd3);
        tick();
        check_eq("drain_valid", a_out.valid, 1'b0);
        check_eq("drain_occ", a_occ, 2'd0);

        // backpressure fills skid entry
        a_out.ready = 1'b0; a_in.valid = 1'b1; a_in.data = 64'hA;
        #1;
        check_eq("bp_ready0", a_in.ready, 1'b1);
        tick();
        a_in.data = 64'hB;
        #1;
        check_eq("bp_ready1", a_in.ready, 1'b1);
        check_eq("bp_occ1", a_occ, 2'd1);
        tick();
        a_in.valid = 1'b0;
        check_eq("bp_occ2", a_occ, 2'd2);
        check_eq("bp_in_ready", a_in.ready, 1'b0);
        check_eq("bp_cnt1", a_cnt, 64'd1);
        tick();
        check_eq("bp_cnt2", a_cnt, 64'd2);
        tick();
        check_eq("bp_cnt3", a_cnt, 64'd3);
        check_eq("bp_outA", a_out.data, 64'hA);
        check_eq("bp_outA_valid", a_out.valid, 1'b1);
        a_out.ready = 1'b1;
        tick();
        check_eq("bp_outB", a_out.data, 64'hB);
        check_eq("bp_outB_valid", a_out.valid, 1'b1);
        check_eq("bp_cnt0", a_cnt, 64'd0);
        check_eq("bp_occ_after", a_occ, 2'd1);
        tick();
        check_eq("bp_empty", a_out.valid, 1'b0);
        check_eq("bp_occ_empty", a_occ, 2'd0);

        // hold with flush on its second cycle
        a_out.ready = 1'b0; a_in.valid = 1'b1; a_in.data = 64'h5;
        tick();
        a_in.valid = 1'b0; a_hold = 1'b1;
        #1;
        check_eq("hold_out_valid", a_out.valid, 1'b0);
        check_eq("hold_in_ready", a_in.ready, 1'b0);
        tick();
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        tick();
        a_hold = 1'b0;
        #1;
        check_eq("hold_cnt3", a_cnt, 64'd3);
        check_eq("hold_kept_occ", a_occ, 2'd1);
        check_eq("hold_kept_data", a_out.data, 64'h5);
        check_eq("kill_out_valid", a_out.valid, 1'b0);
        check_eq("kill_in_ready", a_in.ready, 1'b0);
        tick();
        check_eq("post_kill_occ", a_occ, 2'd0);
        check_eq("post_kill_cnt", a_cnt, 64'd0);
        check_eq("post_kill_in_ready", a_in.ready, 1'b1);
        check_eq("post_kill_data", a_out.data, 64'd0);

        // reset during hold with a pending flush leaves no kill behind
        a_hold = 1'b1; a_flush = 1'b1;
        tick();
        a_flush = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1; a_hold = 1'b0;
        #1;
        check_eq("rst_hold_no_kill", a_in.ready, 1'b1);
        check_eq("rst_hold_cnt", a_cnt, 64'd0);

        // saturating counter on the narrow single-entry stage
        b_in.valid = 1'b1; b_in.data = 8'h3C; b_out.ready = 1'b0;
        tick();
        b_in.valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("sat_cnt", b_cnt, 4'd15);
        check_eq("sat_valid", b_out.valid, 1'b1);
        check_eq("sat_data", b_out.data, 8'h3C);

        // single entry: accept while draining, no bubble
        b_out.ready = 1'b1; b_in.valid = 1'b1; b_in.data = 8'h5A;
        #1;
        check_eq("s0_in_ready", b_in.ready, 1'b1);
        check_eq("s0_old_data", b_out.data, 8'h3C);
        tick();
        b_in.valid = 1'b0;
        check_eq("s0_new_data", b_out.data, 8'h5A);
        check_eq("s0_new_valid", b_out.valid, 1'b1);
        check_eq("s0_cnt0", b_cnt, 4'd0);
        check_eq("s0_occ", b_occ, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
